// File: rtl/aes_inv_round_ctrl_if.sv
// Block-level streams of the AES-128 inverse-round sequencer: ciphertext in, plaintext out.
// The slave side is the sequencer; the master side is its environment.
interface aes_inv_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: walks the external inverse-round datapath NR times
// and fetches round keys from a synchronous key store with one cycle of read latency.
module aes_inv_round_ctrl #(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_inv_round_ctrl_if.slave io,
  output logic [RK_AW-1:0]   rk_addr,
  input  logic [127:0]       rk_data,
  output logic [127:0]       rnd_state,
  output logic [127:0]       rnd_key,
  input  logic [127:0]       rnd_full,
  input  logic [127:0]       rnd_nomix,
  output logic               busy,
  output logic [3:0]         round
);

  typedef enum logic [2:0] {IDLE, ARK0, ROUND, FINAL, DONE} state_t;

  localparam logic [RK_AW-1:0] AddrNr  = RK_AW'(NR);
  localparam logic [RK_AW-1:0] AddrNr1 = RK_AW'(NR - 1);
  localparam logic [RK_AW-1:0] AddrNr2 = RK_AW'(NR - 2);
  localparam logic [3:0]       RndNr1  = 4'(NR - 1);

  state_t       fsm;
  logic [127:0] state_q;
  logic         out_valid_q;
  logic         accept;

  assign io.in_ready  = (fsm == IDLE) | ((fsm == DONE) & io.out_ready);
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = state_q;
  assign rnd_state    = state_q;
  assign rnd_key      = rk_data;

  // rk_addr always holds the key index the next state consumes, so the store's one-cycle
  // read latency lines rk_data up with the state that uses it. Between blocks it rests at NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state_q     <= '0;
      rk_addr     <= AddrNr;
      round       <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (accept) begin
            state_q <= io.in_data;
            rk_addr <= AddrNr1;
            busy    <= 1'b1;
            fsm     <= ARK0;
          end
        end
        ARK0: begin
          state_q <= state_q ^ rk_data;
          round   <= RndNr1;
          rk_addr <= AddrNr2;
          fsm     <= ROUND;
        end
        ROUND: begin
          state_q <= rnd_full;
          if (round == 4'd1) begin
            rk_addr <= AddrNr;
            fsm     <= FINAL;
          end else begin
            round   <= round - 4'd1;
            rk_addr <= RK_AW'(round - 4'd2);
          end
        end
        FINAL: begin
          state_q     <= rnd_nomix;
          out_valid_q <= 1'b1;
          fsm         <= DONE;
        end
        DONE: begin
          // Output handshake and a new accept may share this edge: no bubble between blocks.
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            if (io.in_valid) begin
              state_q <= io.in_data;
              rk_addr <= AddrNr1;
              fsm     <= ARK0;
            end else begin
              busy <= 1'b0;
              fsm  <= IDLE;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: models the key store and the inverse-round datapath,
// and scoreboards plaintext against FIPS-197 vectors and a reference decryptor.
module tb_aes_inv_round_ctrl;
  localparam int NR    = 10;
  localparam int RK_AW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [RK_AW-1:0] rk_addr;
  logic [127:0]     rk_data;
  logic [127:0]     rnd_state, rnd_key, rnd_full, rnd_nomix;
  logic             busy;
  logic [3:0]       round;

  aes_inv_round_ctrl_if bus ();

  aes_inv_round_ctrl #(.NR(NR), .RK_AW(RK_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .rnd_state (rnd_state),
    .rnd_key   (rnd_key),
    .rnd_full  (rnd_full),
    .rnd_nomix (rnd_nomix),
    .busy      (busy),
    .round     (round)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] ks    [NR+1];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           last_rise = 0;
  int           prev_rise = 0;
  logic         prev_ov   = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] p, s;
    for (int v = 0; v < 256; v++) begin
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gmul(p, 8'(v));
      if (v == 0) p = 8'h00;
      s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
      sbox[v]  = s;
      isbox[s] = 8'(v);
    end
  endtask

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // InvShiftRows, InvSubBytes, AddRoundKey
  function automatic logic [127:0] inv_nomix(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isbox[b[r + 4*((c - r + 4) % 4)]];
    return o ^ k;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] st;
    st = ct ^ ks[NR];
    for (int r = NR - 1; r >= 1; r--) st = inv_mix(inv_nomix(st, ks[r]));
    return inv_nomix(st, ks[0]);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Key store with one cycle of read latency, and the combinational datapath.
  always @(posedge clk) rk_data <= (rk_addr <= RK_AW'(NR)) ? ks[rk_addr] : '0;

  always_comb begin
    rnd_nomix = inv_nomix(rnd_state, rnd_key);
    rnd_full  = inv_mix(rnd_nomix);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 11);
        prev_rise = last_rise;
        last_rise = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_to", bus.in_ready, 1);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    exp_q.push_back(pt);
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = rnd128();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c1, p1, ct, b1, b2;
    int n;
    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    p1 = 128'h00112233445566778899aabbccddeeff;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    build_tables();
    load_keys(128'h000102030405060708090a0b0c0d0e0f);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rk_addr", rk_addr, NR);
    chk("rst_round", round, 0);
    chk("rst_state", rnd_state, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1 with key-address trace
    bus.in_valid = 1'b1;
    bus.in_data  = c1;
    exp_q.push_back(p1);
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_rk_addr", rk_addr, NR);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = rnd128();
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      chk("rk_addr_trace", rk_addr, NR - 1 - i);
      chk("busy_run", busy, 1);
    end
    wait_drain();

    // Backpressure in DONE
    bus.out_ready = 1'b0;
    ct = rnd128();
    b1 = ref_decrypt(ct);
    send(ct, b1);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", bus.out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", bus.out_data, b1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_valid_hold", bus.out_valid, 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back blocks
    b1 = rnd128();
    b2 = rnd128();
    exp_q.push_back(ref_decrypt(b1));
    exp_q.push_back(ref_decrypt(b2));
    bus.in_valid = 1'b1;
    bus.in_data  = b1;
    wait_accept();
    @(posedge clk); #1;
    bus.in_data = b2;
    wait_accept();
    chk("b2b_same_cycle", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();
    chk("b2b_spacing", last_rise - prev_rise, 12);

    // Reset in the middle of a block
    bus.in_valid = 1'b1;
    bus.in_data  = rnd128();
    wait_accept();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (round != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("mid_round5", round, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_state", rnd_state, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    chk("mid_rk_addr", rk_addr, NR);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    ct = rnd128();
    send(ct, ref_decrypt(ct));
    wait_drain();

    // All-zero key
    load_keys('0);
    send(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0);
    wait_drain();

    // Random keys and blocks
    load_keys(rnd128());
    for (int i = 0; i < 3; i++) begin
      ct = rnd128();
      send(ct, ref_decrypt(ct));
      wait_drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
